smallcalc_cu: RTL and testbench

SMALLCALC_CU -- requirements
Module: smallcalc_cu

---
 rtl/smallcalc_pkg.sv | 23 ++
 rtl/smallcalc_cu.sv | 117 +++++++++++
 tb/tb_smallcalc_cu.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/smallcalc_pkg.sv
// smallcalc_pkg: shared state codes, mux selects and register addresses (CLEAR exists only with SMALLCALC_CU_CLEAR_EN)
package smallcalc_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    EXEC   = 3'd3,
    DONE   = 3'd4
`ifdef SMALLCALC_CU_CLEAR_EN
    , CLEAR = 3'd5
`endif
  } state_t;
  localparam logic [1:0] S1_IN1  = 2'b00;
  localparam logic [1:0] S1_IN2  = 2'b01;
  localparam logic [1:0] S1_ZERO = 2'b10;
  localparam logic [1:0] S1_ALU  = 2'b11;
  localparam logic S2_ZERO = 1'b0;
  localparam logic S2_ALU  = 1'b1;
  localparam logic [1:0] R0 = 2'b00;
  localparam logic [1:0] R1 = 2'b01;
  localparam logic [1:0] R2 = 2'b10;
  localparam logic [1:0] R3 = 2'b11;
endpackage

// File: rtl/smallcalc_cu.sv
// smallcalc_cu: Moore control unit sequencing load/load/exec/done for a register-file ALU datapath; SMALLCALC_CU_CLEAR_EN adds a reset-time register clear
module smallcalc_cu
  import smallcalc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [1:0] op,
  output logic [1:0] s1,
  output logic       s2,
  output logic       we,
  output logic [1:0] wa,
  output logic       rea,
  output logic [1:0] raa,
  output logic       reb,
  output logic [1:0] rab,
  output logic [1:0] c,
  output logic       done,
  output logic [2:0] cs
);
  state_t state, next;
  logic [1:0] op_q;
`ifdef SMALLCALC_CU_CLEAR_EN
  logic [1:0] cnt;
  localparam state_t RST_ST = CLEAR;
`else
  localparam state_t RST_ST = IDLE;
`endif

  // state register, op capture on start, clear counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RST_ST;
      op_q  <= 2'b00;
`ifdef SMALLCALC_CU_CLEAR_EN
      cnt   <= 2'b00;
`endif
    end else begin
      state <= next;
      if (state == IDLE && go) op_q <= op;
`ifdef SMALLCALC_CU_CLEAR_EN
      cnt <= (state == CLEAR) ? cnt + 2'd1 : cnt;
`endif
    end
  end

  // next-state logic; go only matters in IDLE and DONE
  always_comb begin
    next = IDLE;
    case (state)
      IDLE:   next = go ? LOAD_A : IDLE;
      LOAD_A: next = LOAD_B;
      LOAD_B: next = EXEC;
      EXEC:   next = DONE;
      DONE:   next = go ? DONE : IDLE;
`ifdef SMALLCALC_CU_CLEAR_EN
      CLEAR:  next = (cnt == 2'b11) ? IDLE : CLEAR;
`endif
      default: next = IDLE;
    endcase
  end

  // Moore output decode from the state register only
  always_comb begin
    s1   = S1_IN1;
    s2   = S2_ZERO;
    we   = 1'b0;
    wa   = R0;
    rea  = 1'b0;
    raa  = R0;
    reb  = 1'b0;
    rab  = R0;
    c    = 2'b00;
    done = 1'b0;
    cs   = state;
    case (state)
      LOAD_A: begin
        s1 = S1_IN1;
        we = 1'b1;
        wa = R1;
      end
      LOAD_B: begin
        s1 = S1_IN2;
        we = 1'b1;
        wa = R2;
      end
      EXEC: begin
        rea = 1'b1;
        raa = R1;
        reb = 1'b1;
        rab = R2;
        c   = op_q;
        s1  = S1_ALU;
        we  = 1'b1;
        wa  = R3;
        s2  = S2_ALU;
      end
      DONE: begin
        rea  = 1'b1;
        raa  = R1;
        reb  = 1'b1;
        rab  = R2;
        c    = op_q;
        s2   = S2_ALU;
        done = 1'b1;
      end
`ifdef SMALLCALC_CU_CLEAR_EN
      CLEAR: begin
        s1 = S1_ZERO;
        we = 1'b1;
        wa = cnt;
      end
`endif
      default: ;
    endcase
  end
endmodule

// File: tb/tb_smallcalc_cu.sv
// tb_smallcalc_cu: scoreboard bench for smallcalc_cu with a small register-file/ALU datapath model
module tb_smallcalc_cu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic go = 1'b0;
  logic [1:0] op = 2'b00;
  logic [1:0] s1, wa, raa, rab, c;
  logic s2, we, rea, reb, done;
  logic [2:0] cs;
  int errors = 0;
  int checks = 0;
  logic [17:0] sb[$];
  logic [7:0] rf[4];
  logic [7:0] in1 = 8'd5;
  logic [7:0] in2 = 8'd3;
  logic [7:0] a, b, alu, dp_out, wdata;

  smallcalc_cu dut (
    .clk(clk), .rst(rst), .go(go), .op(op), .s1(s1), .s2(s2), .we(we), .wa(wa),
    .rea(rea), .raa(raa), .reb(reb), .rab(rab), .c(c), .done(done), .cs(cs)
  );

  always #5 clk = ~clk;

  // datapath model: op 00 add, 01 sub, 10 and, 11 or
  always_comb begin
    a = rea ? rf[raa] : 8'd0;
    b = reb ? rf[rab] : 8'd0;
    alu = (c == 2'b00) ? a + b : (c == 2'b01) ? a - b : (c == 2'b10) ? (a & b) : (a | b);
    dp_out = s2 ? alu : 8'd0;
    wdata = (s1 == 2'b00) ? in1 : (s1 == 2'b01) ? in2 : (s1 == 2'b10) ? 8'd0 : alu;
  end

  initial for (int i = 0; i < 4; i++) rf[i] = 8'd0;
  always @(posedge clk) if (we) rf[wa] <= wdata;

  // {cs, s1, s2, we, wa, rea, raa, reb, rab, c, done}
  function automatic logic [17:0] exp_out(input logic [2:0] st, input logic [1:0] oq);
    case (st)
      3'd1: return {3'd1, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0};
      3'd2: return {3'd2, 2'b01, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0};
      3'd3: return {3'd3, 2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 2'b01, 1'b1, 2'b10, oq, 1'b0};
      3'd4: return {3'd4, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 1'b1, 2'b10, oq, 1'b1};
      default: return {st, 15'd0};
    endcase
  endfunction

  function automatic logic [17:0] actual();
    return {cs, s1, s2, we, wa, rea, raa, reb, rab, c, done};
  endfunction

  task automatic push(input logic [2:0] st, input logic [1:0] oq);
    sb.push_back(exp_out(st, oq));
  endtask

  task automatic drain(input int n, input string name);
    logic [17:0] e;
    for (int i = 0; i < n && sb.size() > 0; i++) begin
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (actual() !== e) begin
        errors++;
        $display("FAIL %s[%0d]: got %h expected %h", name, i, actual(), e);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    go = 1'b1;
    op = 2'b11;
    push(3'd0, 2'b00);
    push(3'd0, 2'b00);
    drain(2, "reset");
    rst = 1'b0;
    go = 1'b0;
    push(3'd0, 2'b00);
    drain(1, "reset_idle");
  endtask

  task automatic test_held_sequence();
    go = 1'b1;
    op = 2'b01;
    push(3'd1, 2'b01);
    push(3'd2, 2'b01);
    push(3'd3, 2'b01);
    push(3'd4, 2'b01);
    push(3'd4, 2'b01);
    push(3'd4, 2'b01);
    drain(6, "held_seq");
    go = 1'b0;
    push(3'd0, 2'b00);
    drain(1, "held_release");
  endtask

  task automatic test_op_change();
    go = 1'b1;
    op = 2'b01;
    push(3'd1, 2'b01);
    drain(1, "opchg_la");
    op = 2'b10;
    push(3'd2, 2'b01);
    drain(1, "opchg_lb");
    op = 2'b11;
    push(3'd3, 2'b01);
    push(3'd4, 2'b01);
    drain(2, "opchg_exec_done");
    go = 1'b0;
    push(3'd0, 2'b00);
    drain(1, "opchg_idle");
  endtask

  task automatic test_ignore_go();
    go = 1'b1;
    op = 2'b10;
    push(3'd1, 2'b10);
    drain(1, "ign_la");
    go = 1'b0;
    push(3'd2, 2'b10);
    drain(1, "ign_lb");
    go = 1'b1;
    push(3'd3, 2'b10);
    drain(1, "ign_exec");
    go = 1'b0;
    push(3'd4, 2'b10);
    push(3'd0, 2'b00);
    push(3'd0, 2'b00);
    drain(3, "ign_tail");
  endtask

  task automatic test_back_to_back();
    go = 1'b1;
    op = 2'b11;
    push(3'd1, 2'b11);
    push(3'd2, 2'b11);
    push(3'd3, 2'b11);
    push(3'd4, 2'b11);
    push(3'd4, 2'b11);
    drain(5, "b2b_first");
    go = 1'b0;
    push(3'd0, 2'b00);
    drain(1, "b2b_gap");
    go = 1'b1;
    op = 2'b10;
    push(3'd1, 2'b10);
    push(3'd2, 2'b10);
    push(3'd3, 2'b10);
    push(3'd4, 2'b10);
    drain(4, "b2b_second");
    go = 1'b0;
    push(3'd0, 2'b00);
    drain(1, "b2b_idle");
  endtask

  task automatic test_datapath();
    int seen;
    seen = 0;
    in1 = 8'd5;
    in2 = 8'd3;
    go = 1'b1;
    op = 2'b00;
    @(posedge clk);
    #1;
    go = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        seen++;
        checks++;
        if (dp_out !== 8'd8) begin
          errors++;
          $display("FAIL dp_out: got %0d expected 8", dp_out);
        end
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (seen != 1) begin
      errors++;
      $display("FAIL dp_done_cycles: got %0d expected 1", seen);
    end
    checks++;
    if (rf[3] !== 8'd8) begin
      errors++;
      $display("FAIL dp_r3: got %0d expected 8", rf[3]);
    end
  endtask

  task automatic test_abort();
    go = 1'b1;
    op = 2'b10;
    push(3'd1, 2'b10);
    push(3'd2, 2'b10);
    push(3'd3, 2'b10);
    drain(3, "abort_pre");
    rst = 1'b1;
    push(3'd0, 2'b00);
    drain(1, "abort_rst");
    rst = 1'b0;
    go = 1'b0;
    push(3'd0, 2'b00);
    drain(1, "abort_idle");
    go = 1'b1;
    op = 2'b01;
    push(3'd1, 2'b01);
    push(3'd2, 2'b01);
    push(3'd3, 2'b01);
    push(3'd4, 2'b01);
    drain(4, "abort_rerun");
    go = 1'b0;
    push(3'd0, 2'b00);
    drain(1, "abort_end");
  endtask

  task automatic test_illegal();
    force dut.state = smallcalc_pkg::state_t'(3'd7);
    #1;
    checks++;
    if (actual() !== exp_out(3'd7, 2'b00)) begin
      errors++;
      $display("FAIL illegal_out: got %h expected %h", actual(), exp_out(3'd7, 2'b00));
    end
    release dut.state;
    push(3'd0, 2'b00);
    drain(1, "illegal_recover");
  endtask

  initial begin
    test_reset();
    test_held_sequence();
    test_op_change();
    test_ignore_go();
    test_back_to_back();
    test_datapath();
    test_abort();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
